codec_i2c_cfg_seq: RTL and testbench

//  Hardware I2C write sequencer for the WM8750 codec control port; replaces GPIO bit-bang of codec_scl/codec_sda.

---
 rtl/codec_i2c_cfg_seq.sv | 208 ++++++++++++++++++++
 tb/tb_codec_i2c_cfg_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/codec_i2c_cfg_seq.sv
// WM8750 config sequencer: walks a register table and writes each word as a 3-byte I2C write.
// Latency: each write takes 116 quarter periods plus GAP_Q. No backpressure: start_i is ignored while busy_o is high.
module codec_i2c_cfg_seq #(
  parameter int         CLK_FREQ = 50000000,
  parameter int         I2C_FREQ = 100000,
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         NUM_REGS = 16,
  parameter int         GAP_Q    = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [4:0]  cfg_idx_o,
  input  logic [15:0] cfg_word_i,
  output logic        scl_oe_o,
  output logic        sda_oe_o,
  input  logic        sda_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [4:0]  err_idx_o
);

  localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int QCW  = $clog2(((GAP_Q > 4) ? GAP_Q : 4) + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_BITS, S_STOP, S_GAP, S_DONE
  } state_t;

  state_t          r_state;
  logic [QW-1:0]   r_qcnt;
  logic [QCW-1:0]  r_q;
  logic [23:0]     r_shift;
  logic [3:0]      r_bit;
  logic [1:0]      r_byte;
  logic            r_nack;
  logic [5:0]      r_idx;
  logic            r_scl_oe;
  logic            r_sda_oe;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [4:0]      r_err_idx;

  logic w_qend;
  logic w_ack;
  logic w_timed;
  logic w_sample;
  logic w_nack;
  logic w_scl_oe;
  logic w_sda_oe;

  assign w_qend   = (r_qcnt == QW'(QDIV - 1));
  assign w_ack    = (r_bit == 4'd8);
  assign w_timed  = (r_state == S_START) || (r_state == S_BITS) ||
                    (r_state == S_STOP)  || (r_state == S_GAP);
  // Pins lag the phase counter by one clock, so this is the last clock of the pin-level q2.
  assign w_sample = (r_state == S_BITS) && w_ack && (r_q == QCW'(3)) && (r_qcnt == '0);
  assign w_nack   = r_nack || (w_sample && sda_i);

  always_comb begin
    w_scl_oe = 1'b0;
    w_sda_oe = 1'b0;
    case (r_state)
      S_START: begin
        w_scl_oe = (r_q >= QCW'(2));
        w_sda_oe = (r_q >= QCW'(1));
      end
      S_BITS: begin
        w_scl_oe = (r_q == QCW'(0)) || (r_q == QCW'(3));
        w_sda_oe = !w_ack && !r_shift[23];
      end
      S_STOP: begin
        w_scl_oe = (r_q == QCW'(0));
        w_sda_oe = (r_q <= QCW'(1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_qcnt    <= '0;
      r_q       <= '0;
      r_shift   <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_nack    <= 1'b0;
      r_idx     <= '0;
      r_scl_oe  <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else begin
      r_done   <= 1'b0;
      r_scl_oe <= w_scl_oe;
      r_sda_oe <= w_sda_oe;
      if (w_timed) r_qcnt <= w_qend ? '0 : r_qcnt + QW'(1);
      if (w_sample && sda_i) r_nack <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_qcnt <= '0;
          if (start_i) begin
            r_state <= S_LOAD;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cfg_word_i == 16'hFFFF || r_idx == 6'(NUM_REGS)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_shift <= {DEV_ADDR, 1'b0, cfg_word_i};
            r_bit   <= '0;
            r_byte  <= '0;
            r_nack  <= 1'b0;
            r_q     <= '0;
            r_qcnt  <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_qend) begin
            if (r_q == QCW'(3)) begin
              r_q     <= '0;
              r_state <= S_BITS;
            end else begin
              r_q <= r_q + QCW'(1);
            end
          end
        end
        S_BITS: begin
          if (w_qend) begin
            if (r_q == QCW'(3)) begin
              r_q <= '0;
              if (w_ack) begin
                r_bit <= '0;
                if (w_nack) begin
                  r_err     <= 1'b1;
                  r_err_idx <= r_idx[4:0];
                  r_state   <= S_STOP;
                end else if (r_byte == 2'd2) begin
                  r_state <= S_STOP;
                end else begin
                  r_byte <= r_byte + 2'd1;
                end
              end else begin
                r_bit   <= r_bit + 4'd1;
                r_shift <= {r_shift[22:0], 1'b0};
              end
            end else begin
              r_q <= r_q + QCW'(1);
            end
          end
        end
        S_STOP: begin
          if (w_qend) begin
            if (r_q == QCW'(3)) begin
              r_q <= '0;
              // A NACK aborts the rest of the table.
              if (r_nack) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_GAP;
              end
            end else begin
              r_q <= r_q + QCW'(1);
            end
          end
        end
        S_GAP: begin
          if (w_qend) begin
            if (r_q == QCW'(GAP_Q - 1)) begin
              r_q     <= '0;
              r_idx   <= r_idx + 6'd1;
              r_state <= S_LOAD;
            end else begin
              r_q <= r_q + QCW'(1);
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_idx_o = r_idx[4:0];
  assign scl_oe_o  = r_scl_oe;
  assign sda_oe_o  = r_sda_oe;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign err_idx_o = r_err_idx;

endmodule

// File: tb/tb_codec_i2c_cfg_seq.sv
// Bench for codec_i2c_cfg_seq: table vectors plus random tables against a byte-level model,
// with an open-drain bus monitor and ACK/NACK slave.
module tb_codec_i2c_cfg_seq;

  localparam int Q    = 1600000 / (4 * 100000);
  localparam int NREG = 4;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [4:0]  cfg_idx, err_idx;
  logic [15:0] w_word;
  logic        scl_oe, sda_oe, busy, done, err;
  logic        slave_oe;
  logic        scl_line, sda_line;
  logic [15:0] tbl [32];

  always #5 clk = ~clk;

  assign w_word   = tbl[cfg_idx];
  assign scl_line = ~scl_oe;
  assign sda_line = ~(sda_oe | slave_oe);

  codec_i2c_cfg_seq #(
    .CLK_FREQ(1600000), .I2C_FREQ(100000), .DEV_ADDR(7'h1A), .NUM_REGS(NREG), .GAP_Q(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_idx_o(cfg_idx), .cfg_word_i(w_word),
    .scl_oe_o(scl_oe), .sda_oe_o(sda_oe), .sda_i(sda_line), .busy_o(busy), .done_o(done),
    .err_o(err), .err_idx_o(err_idx)
  );

  // Bus monitor and slave: decodes bytes, checks bit timing and START/STOP placement.
  logic       mon_en, mon_clr;
  int         nack_at;
  logic [7:0] got_q [$];
  logic [7:0] cur_byte;
  logic       prev_scl, prev_sda, ev;
  int         rises, hi_len, lo_len, n_start, n_stop, n_viol;

  always @(negedge clk) begin
    if (mon_clr || !mon_en) begin
      if (mon_clr) begin
        got_q.delete();
        n_start = 0; n_stop = 0; n_viol = 0;
      end
      rises = 0; ev = 1'b1; hi_len = 0; lo_len = 0; slave_oe = 1'b0; cur_byte = 8'h00;
    end else begin
      if (scl_line && prev_scl && (sda_line != prev_sda)) begin
        ev = 1'b1;
        if (!sda_line) begin
          n_start++;
          if (rises != 0) begin n_viol++; $display("protocol: START inside frame at %0t", $time); end
          rises = 0; cur_byte = 8'h00;
        end else begin
          n_stop++;
          if (rises < 1 || (rises - 1) % 9 != 0) begin
            n_viol++; $display("protocol: STOP off byte boundary at %0t", $time);
          end
          rises = 0;
        end
      end
      if (scl_line && !prev_scl) begin
        if (rises >= 1 && lo_len != 2 * Q) begin
          n_viol++; $display("protocol: SCL low %0d clocks at %0t", lo_len, $time);
        end
        rises++; hi_len = 1; ev = 1'b0;
        if (rises % 9 != 0) cur_byte = {cur_byte[6:0], sda_line};
        if (rises % 9 == 8) got_q.push_back(cur_byte);
      end else if (!scl_line && prev_scl) begin
        if (!ev && hi_len != 2 * Q) begin
          n_viol++; $display("protocol: SCL high %0d clocks at %0t", hi_len, $time);
        end
        lo_len = 1;
        if (rises > 0 && rises % 9 == 8) slave_oe = (got_q.size() - 1 != nack_at);
        else if (rises > 0 && rises % 9 == 0) slave_oe = 1'b0;
      end else if (scl_line) hi_len++;
      else lo_len++;
    end
    prev_scl = scl_line;
    prev_sda = sda_line;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: bytes on the bus are 0x34, word[15:8], word[7:0] per entry until the end
  // marker, the entry limit, or the NACKed byte.
  task automatic run_seq(input string tag, input int nack, input int restart_at,
                         output int o_err, output int o_idx);
    logic [7:0] exp_b [$];
    logic [7:0] tri_b [3];
    int n_wr, d_exp, idx_exp, c, lim, nb;
    bit hit;
    n_wr = 0; hit = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (hit || tbl[i] == 16'hFFFF || i == NREG) break;
      n_wr++;
      tri_b[0] = 8'h34; tri_b[1] = tbl[i][15:8]; tri_b[2] = tbl[i][7:0];
      for (int b = 0; b < 3; b++) begin
        if (!hit) begin
          exp_b.push_back(tri_b[b]);
          if (exp_b.size() - 1 == nack) hit = 1'b1;
        end
      end
    end
    if (hit) begin
      idx_exp = nack / 3;
      d_exp   = idx_exp * (1 + 124 * Q) + 1 + (8 + 36 * (nack % 3 + 1)) * Q;
    end else begin
      idx_exp = n_wr;
      d_exp   = n_wr * (1 + 124 * Q) + 1;
    end

    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    nack_at = nack;
    start = 1'b1; tick(); start = 1'b0;
    chk({tag, ".busy_rise"}, int'(busy), 1);
    c = 0; lim = d_exp + 200;
    while (done !== 1'b1 && c < lim) begin
      if (c == restart_at) start = 1'b1;
      tick();
      start = 1'b0;
      c++;
    end
    chk({tag, ".done_at"}, c, d_exp);
    chk({tag, ".busy_in_done"}, int'(busy), 1);
    chk({tag, ".err"}, int'(err), int'(hit));
    if (hit) chk({tag, ".err_idx"}, int'(err_idx), idx_exp);
    chk({tag, ".cfg_idx"}, int'(cfg_idx), idx_exp);
    o_err = int'(err); o_idx = int'(cfg_idx);
    tick();
    chk({tag, ".done_pulse"}, int'(done), 0);
    chk({tag, ".busy_fall"}, int'(busy), 0);
    chk({tag, ".starts"}, n_start, n_wr);
    chk({tag, ".stops"}, n_stop, n_wr);
    chk({tag, ".nbytes"}, got_q.size(), exp_b.size());
    nb = (got_q.size() < exp_b.size()) ? got_q.size() : exp_b.size();
    for (int i = 0; i < nb; i++) chk({tag, ".byte"}, int'(got_q[i]), int'(exp_b[i]));
    chk({tag, ".proto"}, n_viol, 0);
  endtask

  typedef struct {
    logic [4:0][15:0] w;
    int nack, exp_err, exp_idx, restart_at;
  } vec_t;

  function automatic vec_t mkv(input logic [15:0] a, b, c, d, e,
                               input int nk, er, ix, rs);
    vec_t v;
    v.w = {e, d, c, b, a};
    v.nack = nk; v.exp_err = er; v.exp_idx = ix; v.restart_at = rs;
    return v;
  endfunction

  vec_t vt [7];
  int   g_err, g_idx, nrand, dn;

  initial begin
    vt[0] = mkv(16'h1E00, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 0, 1, -1);
    vt[1] = mkv(16'h0E02, 16'h32C0, 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 0, 2, 300);
    vt[2] = mkv(16'h0E02, 16'h32C0, 16'h1234, 16'hFFFF, 16'hFFFF,  5, 1, 1, -1);
    vt[3] = mkv(16'h0E02, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 0, 1, -1);
    vt[4] = mkv(16'hFFFF, 16'h1111, 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 0, 0, -1);
    vt[5] = mkv(16'h0001, 16'h0203, 16'h0405, 16'h0607, 16'h0809, -1, 0, 4, -1);
    vt[6] = mkv(16'hABCD, 16'h5555, 16'hFFFF, 16'hFFFF, 16'hFFFF,  0, 1, 0, -1);

    rst = 1'b1; start = 1'b0; mon_en = 1'b0; mon_clr = 1'b0; nack_at = -1;
    for (int i = 0; i < 32; i++) tbl[i] = 16'hFFFF;
    repeat (3) tick();
    chk("rst.scl_oe", int'(scl_oe), 0);
    chk("rst.sda_oe", int'(sda_oe), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.err", int'(err), 0);
    chk("rst.err_idx", int'(err_idx), 0);
    chk("rst.cfg_idx", int'(cfg_idx), 0);
    rst = 1'b0; mon_en = 1'b1;
    tick();

    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 32; i++) tbl[i] = (i < 5) ? vt[k].w[i] : 16'hFFFF;
      run_seq($sformatf("vec%0d", k), vt[k].nack, vt[k].restart_at, g_err, g_idx);
      chk($sformatf("vec%0d.tbl_err", k), g_err, vt[k].exp_err);
      chk($sformatf("vec%0d.tbl_idx", k), g_idx, vt[k].exp_idx);
      repeat (5) tick();
    end

    // Reset while shifting the first byte: lines released next clock, no done pulse.
    for (int i = 0; i < 32; i++) tbl[i] = (i < 5) ? vt[1].w[i] : 16'hFFFF;
    mon_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (1 + 14 * Q) tick();
    chk("rstmid.busy_before", int'(busy), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstmid.scl_oe", int'(scl_oe), 0);
    chk("rstmid.sda_oe", int'(sda_oe), 0);
    chk("rstmid.busy", int'(busy), 0);
    chk("rstmid.done", int'(done), 0);
    dn = 0;
    repeat (50) begin tick(); if (done) dn++; end
    chk("rstmid.no_done", dn, 0);
    mon_en = 1'b1;
    tick();

    for (int r = 0; r < 8; r++) begin
      nrand = int'($urandom_range(1, 3));
      for (int i = 0; i < 32; i++) tbl[i] = 16'hFFFF;
      for (int i = 0; i < nrand; i++) tbl[i] = 16'($urandom_range(0, 16'hFFFE));
      run_seq($sformatf("rnd%0d", r),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3 * nrand - 1)) : -1,
              -1, g_err, g_idx);
      repeat (3) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
